io_pin_cond: RTL and testbench

Per-pin conditioning stage between the chip pads and the IO filter. It has three jobs:
- On the input side, it synchronises each pad, debounces it with a programmable stability window and flags edges, then presents clean levels on `pin_data_in` for the filter.
- On the output side, it registers the filter's `pin_data_out` and `pin_dir` into pad-facing data and output-enable bits.
- Pins configured as outputs loop back their driven value, so the filter always sees a coherent view of every pin.

---
 rtl/io_pin_cond.sv | 66 ++++++
 tb/tb_io_pin_cond.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/io_pin_cond.sv
// Per-pin pad conditioning: synchronise, debounce and edge-detect inputs,
// register pad drive/enable, and loop driven pins back to the filter.
module io_pin_cond #(
  parameter int IO_PINS     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_BITS     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IO_PINS-1:0] pad_in,
  output logic [IO_PINS-1:0] pad_out,
  output logic [IO_PINS-1:0] pad_oe,
  input  logic [IO_PINS-1:0] pin_dir,
  input  logic [IO_PINS-1:0] pin_data_out,
  output logic [IO_PINS-1:0] pin_data_in,
  input  logic [DB_BITS-1:0] debounce_len,
  output logic [IO_PINS-1:0] rise,
  output logic [IO_PINS-1:0] fall
);

  logic [IO_PINS-1:0] r_sync [SYNC_STAGES];
  logic [IO_PINS-1:0] r_filt;
  logic [DB_BITS-1:0] r_cnt [IO_PINS];

  logic [IO_PINS-1:0] w_s;
  logic [IO_PINS-1:0] w_filt_next;
  logic [DB_BITS-1:0] w_cnt_next [IO_PINS];

  // Counter clears at or before debounce_len, so it can never wrap.
  always_comb begin
    w_s = r_sync[SYNC_STAGES-1];
    for (int unsigned i = 0; i < IO_PINS; i++) begin
      w_filt_next[i] = r_filt[i];
      w_cnt_next[i]  = '0;
      if (w_s[i] != r_filt[i]) begin
        if (r_cnt[i] >= debounce_len) w_filt_next[i] = w_s[i];
        else                          w_cnt_next[i]  = r_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      for (int unsigned i = 0; i < IO_PINS; i++)     r_cnt[i]  <= '0;
      r_filt  <= '0;
      pad_out <= '0;
      pad_oe  <= '0;
      rise    <= '0;
      fall    <= '0;
    end else begin
      r_sync[0] <= pad_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      for (int unsigned i = 0; i < IO_PINS; i++)     r_cnt[i]  <= w_cnt_next[i];
      r_filt  <= w_filt_next;
      // Edges use the pre-edge enable so a pin driving this cycle stays masked.
      rise    <= ~pad_oe & ~r_filt &  w_filt_next;
      fall    <= ~pad_oe &  r_filt & ~w_filt_next;
      pad_out <= pin_data_out;
      pad_oe  <= pin_dir;
    end
  end

  assign pin_data_in = (pad_oe & pad_out) | (~pad_oe & r_filt);

endmodule

// File: tb/tb_io_pin_cond.sv
// Randomised scoreboard bench for io_pin_cond with directed edge/glitch/loopback scenarios.
module tb_io_pin_cond;
  localparam int N   = 16;
  localparam int SS  = 2;
  localparam int DBB = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] pad_in, pad_out, pad_oe, pin_dir, pin_data_out, pin_data_in, rise, fall;
  logic [DBB-1:0] debounce_len;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] po, oe, pdi, ri, fa;
  } exp_t;
  exp_t q[$];

  io_pin_cond #(.IO_PINS(N), .SYNC_STAGES(SS), .DB_BITS(DBB)) dut (
    .clk(clk), .rst(rst), .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe),
    .pin_dir(pin_dir), .pin_data_out(pin_data_out), .pin_data_in(pin_data_in),
    .debounce_len(debounce_len), .rise(rise), .fall(fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pads pass through an SS-deep delay line; a pin's level is
  // accepted once it has disagreed with the held level for more than debounce_len cycles.
  logic [N-1:0] m_pipe [SS];
  logic [N-1:0] m_f, m_oe, m_out;
  int           m_run [N];

  always @(posedge clk) begin
    exp_t e;
    logic [N-1:0] s, r, fl;
    r = '0; fl = '0;
    if (rst) begin
      for (int k = 0; k < SS; k++) m_pipe[k] = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_f = '0; m_oe = '0; m_out = '0;
    end else begin
      s = m_pipe[SS-1];
      for (int i = 0; i < N; i++) begin
        logic nf;
        nf = m_f[i];
        if (s[i] != m_f[i]) begin
          if (m_run[i] >= int'(debounce_len)) begin nf = s[i]; m_run[i] = 0; end
          else m_run[i] = m_run[i] + 1;
        end else m_run[i] = 0;
        if (!m_oe[i] && m_f[i] != nf) begin
          if (nf) r[i] = 1'b1; else fl[i] = 1'b1;
        end
        m_f[i] = nf;
      end
      for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = pad_in;
      m_oe  = pin_dir;
      m_out = pin_data_out;
    end
    e.po  = m_out;
    e.oe  = m_oe;
    e.pdi = (m_oe & m_out) | (~m_oe & m_f);
    e.ri  = r;
    e.fa  = fl;
    q.push_back(e);
  end

  // Monitor: every clock the DUT presents a full output set; compare against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pad_out",     pad_out,     e.po);
      chk("pad_oe",      pad_oe,      e.oe);
      chk("pin_data_in", pin_data_in, e.pdi);
      chk("rise",        rise,        e.ri);
      chk("fall",        fall,        e.fa);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1'b1;
    pad_in = N'($urandom); pin_dir = N'($urandom); pin_data_out = N'($urandom);
    debounce_len = DBB'($urandom);
    tick();
    chk("reset_pad_out", pad_out, '0);
    chk("reset_pad_oe",  pad_oe,  '0);
    chk("reset_pdi",     pin_data_in, '0);
    chk("reset_edges",   rise | fall, '0);
    for (int k = 0; k < 3; k++) begin
      pad_in = N'($urandom); pin_dir = N'($urandom); pin_data_out = N'($urandom);
      tick();
    end

    rst = 1'b0; pad_in = '0; pin_dir = '0; pin_data_out = '0; debounce_len = 4'd3;
    ticks(8);

    // Clean edge on pin 0: accepted exactly 6 clocks after the pad change.
    pad_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) chk("edge_pdi_before", {15'b0, pin_data_in[0]}, N'(0));
      if (k == 6) begin
        chk("edge_pdi_at",  {15'b0, pin_data_in[0]}, N'(1));
        chk("edge_rise_at", {15'b0, rise[0]},        N'(1));
      end
      if (k == 7) chk("edge_rise_after", {15'b0, rise[0]}, N'(0));
    end

    // Glitch rejection on pin 5, then an accepted 4-cycle pulse.
    pad_in[5] = 1'b1; ticks(3); pad_in[5] = 1'b0; ticks(10);
    chk("glitch_pdi", {15'b0, pin_data_in[5]}, N'(0));
    pad_in[5] = 1'b1; ticks(4); pad_in[5] = 1'b0; ticks(12);

    // Window lowered mid-count on pin 7.
    debounce_len = 4'd15; pad_in[7] = 1'b1; ticks(SS + 5);
    debounce_len = 4'd0; ticks(4);
    chk("window_pdi", {15'b0, pin_data_in[7]}, N'(1));

    // Output drive and loopback on pin 3, then return to input with f already 1.
    debounce_len = 4'd2; pin_dir[3] = 1'b1;
    for (int k = 0; k < 8; k++) begin pin_data_out[3] = ~pin_data_out[3]; tick(); end
    pad_in[3] = 1'b1; ticks(12);
    pin_dir[3] = 1'b0; ticks(2);
    chk("dir_return_pdi", {15'b0, pin_data_in[3]}, N'(1));
    ticks(4);

    // Randomised traffic with sparse pad changes so debounce windows complete.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) pad_in[i] = ~pad_in[i];
      pin_data_out = N'($urandom);
      if ($urandom_range(0, 31) == 0) pin_dir = N'($urandom);
      if ($urandom_range(0, 63) == 0) debounce_len = DBB'($urandom_range(0, 6));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    ticks(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
